fv_vr_stream_monitor: RTL and testbench

- Formal/simulation monitor that sits directly upstream of the in-order scoreboard.
- Observes the valid/ready input and output streams of a DUT and converts completed handshakes into registered push/pop strobes with data, in the form the scoreboard consumes.
- Also checks valid/ready protocol on both streams, tracks transactions in flight, and bounds stall duration; violations set sticky error bits that drive assertions.

---
 rtl/fv_sb_pkg.sv | 27 ++
 rtl/fv_vr_side_checker.sv | 79 +++++++
 rtl/fv_vr_stream_monitor.sv | 165 ++++++++++++++++
 tb/tb_fv_vr_stream_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_sb_pkg.sv
// Shared definitions for the stream monitor and the in-order scoreboard:
// error-bit positions, handshake FSM states and counter width helper.
package fv_sb_pkg;

  // Positions of the sticky error flags in err
  localparam int ERR_IN_DROP    = 0;
  localparam int ERR_IN_DATA    = 1;
  localparam int ERR_OUT_DROP   = 2;
  localparam int ERR_OUT_DATA   = 3;
  localparam int ERR_UNDERFLOW  = 4;
  localparam int ERR_OVERFLOW   = 5;
  localparam int ERR_IN_STALL   = 6;
  localparam int ERR_OUT_STALL  = 7;
  localparam int ERR_W          = 8;

  // Per-side handshake state: IDLE = no pending offer, WAIT = valid seen without ready
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

  // Width of a counter that must hold the value max inclusive
  function automatic int cnt_w(input int max);
    return $clog2(max) + 1;
  endfunction

endpackage

// File: rtl/fv_vr_side_checker.sv
// Valid/ready protocol checker for one stream side. Tracks a pending offer,
// its held data and the length of the current stall. Error outputs are
// single-cycle flags describing the current cycle; the top makes them sticky.
module fv_vr_side_checker
  import fv_sb_pkg::*;
#(
  parameter int DWIDTH    = 4,
  parameter int MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid,
  input  logic              ready,
  input  logic [DWIDTH-1:0] data,
  output logic              fire,
  output logic              drop_err,
  output logic              data_err,
  output logic              stall_err
);

  localparam int             SW        = cnt_w(MAX_STALL + 1);
  localparam logic [SW-1:0]  STALL_SAT = SW'(MAX_STALL + 1);
  localparam logic [SW-1:0]  STALL_LIM = SW'(MAX_STALL);

  hs_state_e         state_q;
  logic [DWIDTH-1:0] held_q;
  logic [SW-1:0]     cnt_q;

  // Handshake FSM: capture the offer on the first unaccepted cycle, count the stall
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid && !ready) begin
            state_q <= WAIT;
            held_q  <= data;
            cnt_q   <= SW'(1);
          end
        end
        WAIT: begin
          if (!valid || ready) begin
            // Either the offer was withdrawn (flagged below) or it was accepted
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q != STALL_SAT) begin
            cnt_q <= cnt_q + SW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Violation decode for this cycle; the held copy keeps the original offer so
  // a changed payload stays visible for as long as it differs.
  always_comb begin
    fire      = valid && ready;
    drop_err  = (state_q == WAIT) && !valid;
    data_err  = (state_q == WAIT) && valid && (data != held_q);
    // Flag the cycle whose not-ready takes the stall count to MAX_STALL+1
    if (valid && !ready) begin
      if (state_q == WAIT) begin
        stall_err = (cnt_q >= STALL_LIM);
      end else begin
        stall_err = (MAX_STALL == 0);
      end
    end else begin
      stall_err = 1'b0;
    end
  end

endmodule

// File: rtl/fv_vr_stream_monitor.sv
// Stream monitor feeding the in-order scoreboard. Turns completed handshakes
// on the DUT input/output streams into registered push/pop strobes, counts
// transactions in flight and collects sticky protocol error flags.
module fv_vr_stream_monitor
  import fv_sb_pkg::*;
#(
  parameter int DWIDTH    = 4,
  parameter int MAX_TRANS = 16,
  parameter int MAX_STALL = 8,
  parameter int IN_IS_ENV = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  input  logic                          in_ready,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic                          out_valid,
  input  logic                          out_ready,
  input  logic [DWIDTH-1:0]             out_data,
  output logic                          push_valid,
  output logic [DWIDTH-1:0]             push_data,
  output logic                          pop_valid,
  output logic [DWIDTH-1:0]             pop_data,
  output logic [cnt_w(MAX_TRANS)-1:0]   outstanding,
  output logic [ERR_W-1:0]              err
);

  localparam int            OW      = cnt_w(MAX_TRANS);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_TRANS);

  logic in_fire, in_drop, in_data_err, in_stall;
  logic out_fire, out_drop, out_data_err, out_stall;

  fv_vr_side_checker #(
    .DWIDTH    (DWIDTH),
    .MAX_STALL (MAX_STALL)
  ) u_in_side (
    .clk       (clk),
    .rstn      (rstn),
    .valid     (in_valid),
    .ready     (in_ready),
    .data      (in_data),
    .fire      (in_fire),
    .drop_err  (in_drop),
    .data_err  (in_data_err),
    .stall_err (in_stall)
  );

  fv_vr_side_checker #(
    .DWIDTH    (DWIDTH),
    .MAX_STALL (MAX_STALL)
  ) u_out_side (
    .clk       (clk),
    .rstn      (rstn),
    .valid     (out_valid),
    .ready     (out_ready),
    .data      (out_data),
    .fire      (out_fire),
    .drop_err  (out_drop),
    .data_err  (out_data_err),
    .stall_err (out_stall)
  );

  logic              push_valid_q, pop_valid_q;
  logic [DWIDTH-1:0] push_data_q, pop_data_q;
  logic [OW-1:0]     outstanding_q, outstanding_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              underflow, overflow;

  // Both strobes share one register stage so push/pop keep their relative order
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      pop_valid_q  <= 1'b0;
      pop_data_q   <= '0;
    end else begin
      push_valid_q <= in_fire;
      push_data_q  <= in_data;
      pop_valid_q  <= out_fire;
      pop_data_q   <= out_data;
    end
  end

  // In-flight count; a simultaneous push and pop cancel, out-of-range steps clamp
  always_comb begin
    outstanding_d = outstanding_q;
    underflow     = 1'b0;
    overflow      = 1'b0;
    if (in_fire && !out_fire) begin
      if (outstanding_q == OUT_MAX) begin
        overflow = 1'b1;
      end else begin
        outstanding_d = outstanding_q + OW'(1);
      end
    end else if (out_fire && !in_fire) begin
      if (outstanding_q == '0) begin
        underflow = 1'b1;
      end else begin
        outstanding_d = outstanding_q - OW'(1);
      end
    end
  end

  // Sticky error accumulation: this cycle's violations OR'd into the flags
  always_comb begin
    err_d                = err_q;
    err_d[ERR_IN_DROP]   = err_q[ERR_IN_DROP]   | in_drop;
    err_d[ERR_IN_DATA]   = err_q[ERR_IN_DATA]   | in_data_err;
    err_d[ERR_OUT_DROP]  = err_q[ERR_OUT_DROP]  | out_drop;
    err_d[ERR_OUT_DATA]  = err_q[ERR_OUT_DATA]  | out_data_err;
    err_d[ERR_UNDERFLOW] = err_q[ERR_UNDERFLOW] | underflow;
    err_d[ERR_OVERFLOW]  = err_q[ERR_OVERFLOW]  | overflow;
    err_d[ERR_IN_STALL]  = err_q[ERR_IN_STALL]  | in_stall;
    err_d[ERR_OUT_STALL] = err_q[ERR_OUT_STALL] | out_stall;
  end

  // Counter and error flag registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_q <= '0;
      err_q         <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign push_valid  = push_valid_q;
  assign push_data   = push_data_q;
  assign pop_valid   = pop_valid_q;
  assign pop_data    = pop_data_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

  // Input-side rules constrain the environment when it drives the DUT input,
  // otherwise they are obligations on the upstream block.
  generate
    if (IN_IS_ENV != 0) begin : g_in_env
`ifdef FORMAL
      asm_in_drop:  assume property (@(posedge clk) disable iff (!rstn) !err[ERR_IN_DROP]);
      asm_in_data:  assume property (@(posedge clk) disable iff (!rstn) !err[ERR_IN_DATA]);
      asm_in_stall: assume property (@(posedge clk) disable iff (!rstn) !err[ERR_IN_STALL]);
`endif
    end else begin : g_in_dut
`ifdef FORMAL
      ast_in_drop:  assert property (@(posedge clk) disable iff (!rstn) !err[ERR_IN_DROP]);
      ast_in_data:  assert property (@(posedge clk) disable iff (!rstn) !err[ERR_IN_DATA]);
      ast_in_stall: assert property (@(posedge clk) disable iff (!rstn) !err[ERR_IN_STALL]);
`endif
    end
  endgenerate

`ifdef FORMAL
  ast_out_proto:  assert property (@(posedge clk) disable iff (!rstn)
                    err[ERR_OUT_DATA:ERR_OUT_DROP] == 2'b00);
  ast_count:      assert property (@(posedge clk) disable iff (!rstn)
                    err[ERR_OVERFLOW:ERR_UNDERFLOW] == 2'b00);
  ast_out_stall:  assert property (@(posedge clk) disable iff (!rstn) !err[ERR_OUT_STALL]);
  cov_full:       cover property (@(posedge clk) disable iff (!rstn) outstanding == OUT_MAX);
  cov_both_wait:  cover property (@(posedge clk) disable iff (!rstn)
                    (u_in_side.state_q == WAIT) && (u_out_side.state_q == WAIT));
`endif

endmodule

// File: tb/tb_fv_vr_stream_monitor.sv
// Bench for fv_vr_stream_monitor: a table of directed vectors, hand-written
// multi-cycle corner sequences, then random traffic against a reference model.
module tb_fv_vr_stream_monitor;

  localparam int DW        = 4;
  localparam int MAX_TRANS = 16;
  localparam int MAX_STALL = 8;
  localparam int VW        = 1 + DW + 1 + DW + 5 + 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          in_valid = 1'b0, in_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic          push_valid, pop_valid;
  logic [DW-1:0] push_data, pop_data;
  logic [4:0]    outstanding;
  logic [7:0]    err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fv_vr_stream_monitor #(
    .DWIDTH    (DW),
    .MAX_TRANS (MAX_TRANS),
    .MAX_STALL (MAX_STALL),
    .IN_IS_ENV (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .push_valid  (push_valid),
    .push_data   (push_data),
    .pop_valid   (pop_valid),
    .pop_data    (pop_data),
    .outstanding (outstanding),
    .err         (err)
  );

  // ---------------- reference model ----------------
  // Each side is described by how many consecutive cycles the current offer
  // has gone unaccepted and the payload it was first offered with.
  logic          m_pv, m_popv;
  logic [DW-1:0] m_pd, m_popd;
  int            m_outs;
  logic [7:0]    m_err;
  int            in_run, out_run;
  logic [DW-1:0] in_held, out_held;

  task automatic model_reset();
    m_pv = 0; m_popv = 0; m_pd = '0; m_popd = '0;
    m_outs = 0; m_err = '0;
    in_run = 0; out_run = 0; in_held = '0; out_held = '0;
  endtask

  task automatic side_step(input logic v, input logic r, input logic [DW-1:0] d,
                           inout int run, inout logic [DW-1:0] held,
                           output bit drop, output bit chg, output bit stall);
    drop  = (run > 0) && !v;
    chg   = (run > 0) && v && (d != held);
    stall = 0;
    if (v && !r) begin
      if (run == 0) held = d;
      run++;
      stall = (run > MAX_STALL);
    end else begin
      run = 0;
    end
  endtask

  task automatic model_step(input logic iv, input logic ir, input logic [DW-1:0] id,
                            input logic ov, input logic ordy, input logic [DW-1:0] od);
    bit idrop, ichg, istall, odrop, ochg, ostall;
    int nxt;
    bit inf, outf;
    inf  = iv && ir;
    outf = ov && ordy;
    side_step(iv, ir, id, in_run, in_held, idrop, ichg, istall);
    side_step(ov, ordy, od, out_run, out_held, odrop, ochg, ostall);
    nxt = m_outs + (inf ? 1 : 0) - (outf ? 1 : 0);
    if (nxt < 0) begin m_err[4] = 1; nxt = 0; end
    if (nxt > MAX_TRANS) begin m_err[5] = 1; nxt = MAX_TRANS; end
    m_outs = nxt;
    if (idrop)  m_err[0] = 1;
    if (ichg)   m_err[1] = 1;
    if (odrop)  m_err[2] = 1;
    if (ochg)   m_err[3] = 1;
    if (istall) m_err[6] = 1;
    if (ostall) m_err[7] = 1;
    m_pv = inf;  m_pd = id;
    m_popv = outf; m_popd = od;
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {push_valid, push_data, pop_valid, pop_data, outstanding, err};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_pv, m_pd, m_popv, m_popd, 5'(m_outs), m_err};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input bit quiet);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else if (!quiet) begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One clock cycle of stimulus, applied just after an edge, model kept in step
  task automatic cyc(input logic iv, input logic ir, input logic [DW-1:0] id,
                     input logic ov, input logic ordy, input logic [DW-1:0] od);
    in_valid = iv; in_ready = ir; in_data = id;
    out_valid = ov; out_ready = ordy; out_data = od;
    model_step(iv, ir, id, ov, ordy, od);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_ready = 0; in_data = '0;
    out_valid = 0; out_ready = 0; out_data = '0;
    rstn = 0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          iv, ir;
    logic [DW-1:0] id;
    logic          ov, ordy;
    logic [DW-1:0] od;
    logic          epv;
    logic [DW-1:0] epd;
    logic          epopv;
    logic [DW-1:0] epopd;
    logic [4:0]    eouts;
    logic [7:0]    eerr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // iv ir id  ov or od   pv pd  popv popd outs err
    tbl[0]  = '{1, 1, 4'hA, 0, 0, 4'h0, 1, 4'hA, 0, 4'h0, 5'd1, 8'h00};
    tbl[1]  = '{0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 5'd1, 8'h00};
    tbl[2]  = '{0, 0, 4'h0, 1, 1, 4'hA, 0, 4'h0, 1, 4'hA, 5'd0, 8'h00};
    tbl[3]  = '{1, 1, 4'h3, 1, 1, 4'h3, 1, 4'h3, 1, 4'h3, 5'd0, 8'h00};
    tbl[4]  = '{0, 0, 4'h0, 1, 1, 4'h7, 0, 4'h0, 1, 4'h7, 5'd0, 8'h10};
    tbl[5]  = '{1, 0, 4'h5, 0, 0, 4'h0, 0, 4'h5, 0, 4'h0, 5'd0, 8'h10};
    tbl[6]  = '{1, 0, 4'h5, 0, 0, 4'h0, 0, 4'h5, 0, 4'h0, 5'd0, 8'h10};
    tbl[7]  = '{1, 0, 4'h6, 0, 0, 4'h0, 0, 4'h6, 0, 4'h0, 5'd0, 8'h12};
    tbl[8]  = '{1, 1, 4'h6, 0, 0, 4'h0, 1, 4'h6, 0, 4'h0, 5'd1, 8'h12};
    tbl[9]  = '{0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 5'd1, 8'h12};
    tbl[10] = '{1, 0, 4'h9, 0, 0, 4'h0, 0, 4'h9, 0, 4'h0, 5'd1, 8'h12};
    tbl[11] = '{0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 5'd1, 8'h13};
    tbl[12] = '{0, 0, 4'h0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 5'd1, 8'h13};

    model_reset();
    @(posedge clk);
    #1;
    chk("reset_state", 32'(dut_vec()), 32'(0), 0);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].iv, tbl[i].ir, tbl[i].id, tbl[i].ov, tbl[i].ordy, tbl[i].od);
      chk($sformatf("table[%0d]", i), 32'(dut_vec()),
          32'({tbl[i].epv, tbl[i].epd, tbl[i].epopv, tbl[i].epopd, tbl[i].eouts, tbl[i].eerr}), 0);
    end

    // Output stall of MAX_STALL+1 cycles: flag only after the last one
    do_reset();
    cyc(1, 1, 4'h1, 0, 0, 4'h0);
    for (int k = 1; k <= MAX_STALL + 1; k++) begin
      cyc(0, 0, 4'h0, 1, 0, 4'h4);
      if (k == MAX_STALL)     chk("out_stall_at_limit", 32'(err), 32'h00, 0);
      if (k == MAX_STALL + 1) chk("out_stall_exceeded", 32'(err), 32'h80, 0);
    end

    // Output stall of exactly MAX_STALL cycles, then accepted: no flag
    do_reset();
    cyc(1, 1, 4'h2, 0, 0, 4'h0);
    for (int k = 0; k < MAX_STALL; k++) cyc(0, 0, 4'h0, 1, 0, 4'h2);
    cyc(0, 0, 4'h0, 1, 1, 4'h2);
    chk("stall_limit_ok", 32'({pop_valid, pop_data, outstanding, err}),
        32'({1'b1, 4'h2, 5'd0, 8'h00}), 0);

    // Fill to MAX_TRANS, then one more push overflows and holds
    do_reset();
    for (int k = 0; k < MAX_TRANS; k++) cyc(1, 1, 4'(k), 0, 0, 4'h0);
    chk("full_count", 32'({outstanding, err}), 32'({5'd16, 8'h00}), 0);
    cyc(1, 1, 4'hF, 0, 0, 4'h0);
    chk("overflow", 32'({push_valid, outstanding, err}), 32'({1'b1, 5'd16, 8'h20}), 0);

    // Asynchronous reset in the middle of an input stall
    do_reset();
    for (int k = 0; k < 3; k++) cyc(1, 1, 4'h8, 0, 0, 4'h0);
    cyc(1, 0, 4'hC, 0, 0, 4'h0);
    cyc(1, 0, 4'hC, 0, 0, 4'h0);
    chk("pre_reset_outs", 32'(outstanding), 32'd3, 0);
    #2;
    in_valid = 0; in_ready = 0; in_data = '0;
    rstn = 0;
    #1;
    chk("async_reset_clear", 32'(dut_vec()), 32'(0), 0);
    model_reset();
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    cyc(1, 0, 4'hD, 0, 0, 4'h0);
    cyc(1, 0, 4'hD, 0, 0, 4'h0);
    chk("rewait_no_err", 32'({push_valid, outstanding, err}), 32'({1'b0, 5'd0, 8'h00}), 0);
    cyc(1, 1, 4'hD, 0, 0, 4'h0);
    chk("rewait_accept", 32'(dut_vec()), 32'(model_vec()), 0);
    chk("rewait_push", 32'({push_valid, push_data, err}), 32'({1'b1, 4'hD, 8'h00}), 0);

    // Random traffic, offers mostly held stable while stalled
    begin
      logic iv, ir, ov, ordy;
      logic [DW-1:0] id, od;
      iv = 0; ir = 0; ov = 0; ordy = 0; id = '0; od = '0;
      for (int n = 0; n < 3000; n++) begin
        if (n % 300 == 0) begin
          do_reset();
          iv = 0; ir = 0; ov = 0; ordy = 0;
        end
        if (!(iv && !ir && $urandom_range(0, 99) < 97)) begin
          iv = ($urandom_range(0, 99) < 55);
          id = DW'($urandom);
        end
        ir = ($urandom_range(0, 99) < 60);
        if (!(ov && !ordy && $urandom_range(0, 99) < 97)) begin
          ov = ($urandom_range(0, 99) < 55);
          od = DW'($urandom);
        end
        ordy = ($urandom_range(0, 99) < 60);
        cyc(iv, ir, id, ov, ordy, od);
        chk($sformatf("random[%0d]", n), 32'(dut_vec()), 32'(model_vec()), 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
